// File: rtl/mem_pkg.sv
// Shared definitions for the instruction/data memory arbiter: FSM state
// encoding and the default RAM size / fetch starvation limit.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } arb_state_t;

  localparam int MEM_BYTES_DEF  = 4096;
  localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (fetch / load-store) arbiter in front of a single-ported RAM.
// Each access takes two cycles: a grant cycle (IDLE) that issues the RAM
// command, then a response cycle (BUSY_IF / BUSY_D) that returns the data.
// Data normally wins over fetch. Out-of-range accesses are granted but never
// reach the RAM; they complete with zero data (and d_err for the data port).
// Optional feature macro: MEM_ARB_FAIR_EN -- after STARVE_MAX consecutive
// data grants taken while fetch was waiting, fetch is given the next slot.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int MEM_BYTES  = MEM_BYTES_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic        clk,
  input  logic        rst,
  // instruction fetch port
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  // load/store port
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  // RAM side
  output logic [31:0] mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  // Highest legal word start is MEM_BYTES-4; the +3 is done in 33 bits so
  // addresses near 2^32 cannot wrap back into range.
  localparam logic [32:0] LIMIT = 33'(MEM_BYTES);

  arb_state_t r_state;
  arb_state_t w_next;
  logic       r_oor;
  logic       r_we;

  logic       w_if_oor;
  logic       w_d_oor;
  logic       w_fair_force;
  logic       w_pick_d;
  logic       w_pick_if;

  assign w_if_oor = (({1'b0, if_addr} + 33'd3) >= LIMIT);
  assign w_d_oor  = (({1'b0, d_addr}  + 33'd3) >= LIMIT);

`ifdef MEM_ARB_FAIR_EN
  localparam int CNT_W = ($clog2(STARVE_MAX + 1) > 3) ? $clog2(STARVE_MAX + 1) : 3;

  logic [CNT_W-1:0] r_starve;

  assign w_fair_force = (r_starve >= CNT_W'(STARVE_MAX));

  // Count data grants won while fetch was waiting; any fetch grant, or a data
  // grant with fetch idle, ends the streak.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve <= '0;
    end else if (if_gnt) begin
      r_starve <= '0;
    end else if (d_gnt) begin
      if (!if_req) begin
        r_starve <= '0;
      end else if (r_starve < CNT_W'(STARVE_MAX)) begin
        r_starve <= r_starve + 1'b1;
      end
    end
  end
`else
  // Strict data priority: fetch is never forced ahead of data
  // (STARVE_MAX has no effect in this build).
  assign w_fair_force = 1'b0 & (STARVE_MAX > 0);
`endif

  assign w_pick_d  = d_req && !(if_req && w_fair_force);
  assign w_pick_if = if_req && !w_pick_d;

  // State register plus the attributes of the granted access needed in the
  // response cycle (out of range, write).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_oor   <= 1'b0;
      r_we    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (d_gnt) begin
        r_oor <= w_d_oor;
        r_we  <= d_we;
      end else if (if_gnt) begin
        r_oor <= w_if_oor;
        r_we  <= 1'b0;
      end
    end
  end

  // Next state, grants, RAM command and responses; reset forces everything low.
  always_comb begin
    w_next    = r_state;
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    if_rvalid = 1'b0;
    if_rdata  = 32'd0;
    d_rvalid  = 1'b0;
    d_rdata   = 32'd0;
    d_err     = 1'b0;
    mem_addr  = 32'd0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_wdata = 32'd0;

    case (r_state)
      IDLE: begin
        if (w_pick_d) begin
          d_gnt  = 1'b1;
          w_next = BUSY_D;
          if (!w_d_oor) begin
            mem_addr = d_addr;
            if (d_we) begin
              mem_write = 1'b1;
              mem_wdata = d_wdata;
            end else begin
              mem_read = 1'b1;
            end
          end
        end else if (w_pick_if) begin
          if_gnt = 1'b1;
          w_next = BUSY_IF;
          if (!w_if_oor) begin
            mem_addr = if_addr;
            mem_read = 1'b1;
          end
        end
      end
      BUSY_IF: begin
        if_rvalid = 1'b1;
        if_rdata  = r_oor ? 32'd0 : mem_rdata;
        w_next    = IDLE;
      end
      BUSY_D: begin
        d_rvalid = 1'b1;
        d_rdata  = (r_oor || r_we) ? 32'd0 : mem_rdata;
        d_err    = r_oor;
        w_next   = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase

    if (rst) begin
      w_next    = IDLE;
      if_gnt    = 1'b0;
      d_gnt     = 1'b0;
      if_rvalid = 1'b0;
      if_rdata  = 32'd0;
      d_rvalid  = 1'b0;
      d_rdata   = 32'd0;
      d_err     = 1'b0;
      mem_addr  = 32'd0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_wdata = 32'd0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: reset, a table of single accesses,
// hand-written multi-cycle sequences (back-to-back priority, fairness, reset
// in the response cycle) and a randomized run against a transaction model.
module tb_mem_arbiter;

  localparam int MB = 4096;
  localparam int SM = 4;
`ifdef MEM_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, d_err;
  logic [31:0] if_rdata, d_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_BYTES(MB), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 4)     return 32'hDEADBEEF;
    if (i == 1023)  return 32'hCAFEF00D;
    return 32'h1000_0000 + 32'(i);
  endfunction

  // RAM: loaded while rst is high, read data valid the cycle after mem_read,
  // noise on the read bus otherwise.
  logic [31:0] ram [0:1023];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) ram[i] <= init_word(i);
      mem_rdata <= $urandom();
    end else begin
      if (mem_write) ram[mem_addr[11:2]] <= mem_wdata;
      if (mem_read) mem_rdata <= ram[mem_addr[11:2]];
      else          mem_rdata <= $urandom();
    end
  end

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk1 ({tag, " if_gnt"},    if_gnt,    1'b0);
    chk1 ({tag, " d_gnt"},     d_gnt,     1'b0);
    chk1 ({tag, " if_rvalid"}, if_rvalid, 1'b0);
    chk1 ({tag, " d_rvalid"},  d_rvalid,  1'b0);
    chk32({tag, " if_rdata"},  if_rdata,  32'd0);
    chk32({tag, " d_rdata"},   d_rdata,   32'd0);
    chk1 ({tag, " d_err"},     d_err,     1'b0);
    chk1 ({tag, " mem_read"},  mem_read,  1'b0);
    chk1 ({tag, " mem_write"}, mem_write, 1'b0);
    chk32({tag, " mem_addr"},  mem_addr,  32'd0);
    chk32({tag, " mem_wdata"}, mem_wdata, 32'd0);
  endtask

  // Out of range per the address rule, in unbounded arithmetic.
  function automatic bit is_oor(input logic [31:0] a);
    return (longint'(a) + 3 >= longint'(MB));
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return 32'(4093 + $urandom_range(0, 6));
      1:       return 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      default: return 32'h200 + 32'($urandom_range(0, 15) * 4);
    endcase
  endfunction

  typedef struct {
    logic        ifr;
    logic        dr;
    logic        we;
    logic [31:0] ia;
    logic [31:0] da;
    logic [31:0] wd;
    logic [1:0]  g;      // 0 none, 1 fetch, 2 data
    logic        rd;
    logic        wr;
    logic [31:0] ma;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vt [10];

  logic [31:0] gold [0:1023];
  bit          inflight, pend_d, pend_oor;
  logic [31:0] pend_data;
  int          streak;
  bit          saw_if_gnt, saw_d_gnt;
  int          gq [$];

  initial begin
    vt[0] = '{1'b1, 1'b0, 1'b0, 32'h10,       32'h0,   32'h0,        2'd1, 1'b1, 1'b0, 32'h10,  32'hDEADBEEF, 1'b0};
    vt[1] = '{1'b0, 1'b1, 1'b1, 32'h0,        32'h100, 32'h12345678, 2'd2, 1'b0, 1'b1, 32'h100, 32'h0,        1'b0};
    vt[2] = '{1'b0, 1'b1, 1'b0, 32'h0,        32'h100, 32'h0,        2'd2, 1'b1, 1'b0, 32'h100, 32'h12345678, 1'b0};
    vt[3] = '{1'b0, 1'b1, 1'b0, 32'h0,        32'hFFD, 32'h0,        2'd2, 1'b0, 1'b0, 32'h0,   32'h0,        1'b1};
    vt[4] = '{1'b0, 1'b1, 1'b0, 32'h0,        32'hFFC, 32'h0,        2'd2, 1'b1, 1'b0, 32'hFFC, 32'hCAFEF00D, 1'b0};
    vt[5] = '{1'b1, 1'b0, 1'b0, 32'hFFD,      32'h0,   32'h0,        2'd1, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0};
    vt[6] = '{1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h0,   32'h0,        2'd1, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0};
    vt[7] = '{1'b1, 1'b1, 1'b0, 32'h10,       32'h100, 32'h0,        2'd2, 1'b1, 1'b0, 32'h100, 32'h12345678, 1'b0};
    vt[8] = '{1'b0, 1'b1, 1'b1, 32'h0,        32'hFFE, 32'hAAAA5555, 2'd2, 1'b0, 1'b0, 32'h0,   32'h0,        1'b1};
    vt[9] = '{1'b0, 1'b0, 1'b0, 32'h10,       32'h100, 32'h0,        2'd0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0};

    // Reset with both requests asserted: everything must stay low.
    rst = 1'b1;
    if_req = 1'b1; if_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'h5A5A5A5A;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;

    // Table of single accesses from IDLE.
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if_req = vt[k].ifr; if_addr = vt[k].ia;
      d_req = vt[k].dr; d_we = vt[k].we; d_addr = vt[k].da; d_wdata = vt[k].wd;
      @(negedge clk);
      chk1($sformatf("vec%0d if_gnt", k), if_gnt, vt[k].g == 2'd1);
      chk1($sformatf("vec%0d d_gnt", k), d_gnt, vt[k].g == 2'd2);
      chk1($sformatf("vec%0d mem_read", k), mem_read, vt[k].rd);
      chk1($sformatf("vec%0d mem_write", k), mem_write, vt[k].wr);
      if (vt[k].rd || vt[k].wr)
        chk32($sformatf("vec%0d mem_addr", k), mem_addr, vt[k].ma);
      if (vt[k].wr)
        chk32($sformatf("vec%0d mem_wdata", k), mem_wdata, vt[k].wd);
      @(posedge clk); #1;
      if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      @(negedge clk);
      chk1($sformatf("vec%0d if_rvalid", k), if_rvalid, vt[k].g == 2'd1);
      chk1($sformatf("vec%0d d_rvalid", k), d_rvalid, vt[k].g == 2'd2);
      chk1($sformatf("vec%0d d_err", k), d_err, vt[k].err);
      if (vt[k].g == 2'd1) chk32($sformatf("vec%0d if_rdata", k), if_rdata, vt[k].rdata);
      if (vt[k].g == 2'd2) chk32($sformatf("vec%0d d_rdata", k), d_rdata, vt[k].rdata);
    end

    // Simultaneous requests: data first, fetch two cycles later.
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h10; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    @(negedge clk);
    chk1("both d_gnt first", d_gnt, 1'b1);
    chk1("both if_gnt first", if_gnt, 1'b0);
    @(posedge clk); #1; d_req = 1'b0;
    @(negedge clk);
    chk1("both busy if_gnt", if_gnt, 1'b0);
    chk1("both d_rvalid", d_rvalid, 1'b1);
    chk32("both d_rdata", d_rdata, 32'h12345678);
    @(posedge clk); #1;
    @(negedge clk);
    chk1("both if_gnt later", if_gnt, 1'b1);
    @(posedge clk); #1; if_req = 1'b0;
    @(negedge clk);
    chk1("both if_rvalid", if_rvalid, 1'b1);
    chk32("both if_rdata", if_rdata, 32'hDEADBEEF);

    // Both ports requesting continuously: record ten grants.
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h10; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    gq.delete();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (if_gnt) gq.push_back(1);
      if (d_gnt)  gq.push_back(2);
      @(posedge clk); #1;
    end
    if_req = 1'b0; d_req = 1'b0;
    chk32("fair grant count", 32'(gq.size()), 32'd10);
    for (int g = 0; g < 10; g++) begin
      int exp_g;
      exp_g = (FAIR && (g % 5 == 4)) ? 1 : 2;
      chk32($sformatf("fair grant%0d", g), (g < gq.size()) ? 32'(gq[g]) : 32'd0, 32'(exp_g));
    end
    @(posedge clk); #1;

    // Reset asserted in the BUSY_D cycle.
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
    @(negedge clk);
    chk1("rstmid d_gnt", d_gnt, 1'b1);
    @(posedge clk); #1;
    d_req = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk_all_zero("rstmid");
    @(posedge clk); #1; rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk1("rstmid no d_rvalid", d_rvalid, 1'b0);
      chk1("rstmid no d_err", d_err, 1'b0);
      @(posedge clk); #1;
    end
    if_req = 1'b1; if_addr = 32'h10;
    @(negedge clk);
    chk1("rstmid next if_gnt", if_gnt, 1'b1);
    @(posedge clk); #1; if_req = 1'b0;
    @(negedge clk);
    chk1("rstmid next if_rvalid", if_rvalid, 1'b1);
    chk32("rstmid next if_rdata", if_rdata, 32'hDEADBEEF);

    // Randomized traffic against a transaction-level model.
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    for (int i = 0; i < 1024; i++) gold[i] = init_word(i);
    inflight = 0; streak = 0; saw_if_gnt = 0; saw_d_gnt = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      bit fresh_if, fresh_d, take_if, oor;
      bit e_ifg, e_dg, e_rd, e_wr, e_ifv, e_dv, e_err;
      logic [31:0] e_rdata, e_maddr;
      // requesters: hold until granted, occasionally withdraw
      fresh_if = 0; fresh_d = 0;
      if (saw_if_gnt) if_req = 1'b0;
      else if (if_req && $urandom_range(0, 15) == 0) begin if_req = 1'b0; fresh_if = 1; end
      if (saw_d_gnt) d_req = 1'b0;
      else if (d_req && $urandom_range(0, 15) == 0) begin d_req = 1'b0; fresh_d = 1; end
      if (!if_req && !fresh_if && $urandom_range(0, 2) != 0) begin
        if_req = 1'b1; if_addr = rand_addr();
      end
      if (!d_req && !fresh_d && $urandom_range(0, 2) != 0) begin
        d_req = 1'b1; d_addr = rand_addr(); d_we = 1'($urandom_range(0, 1)); d_wdata = $urandom();
      end
      @(negedge clk);
      e_ifg = 0; e_dg = 0; e_rd = 0; e_wr = 0; e_ifv = 0; e_dv = 0; e_err = 0;
      e_rdata = 32'd0; e_maddr = 32'd0;
      if (inflight) begin
        if (pend_d) begin e_dv = 1; e_err = pend_oor; end
        else e_ifv = 1;
        e_rdata = pend_data;
        inflight = 0;
      end else if (if_req || d_req) begin
        take_if = if_req && (!d_req || (FAIR && streak >= SM));
        if (take_if) begin
          e_ifg = 1; oor = is_oor(if_addr);
          e_rd = !oor; e_maddr = if_addr;
          pend_data = oor ? 32'd0 : gold[if_addr[11:2]];
          streak = 0;
        end else begin
          e_dg = 1; oor = is_oor(d_addr); e_maddr = d_addr;
          if (d_we) begin
            e_wr = !oor; pend_data = 32'd0;
            if (!oor) gold[d_addr[11:2]] = d_wdata;
          end else begin
            e_rd = !oor;
            pend_data = oor ? 32'd0 : gold[d_addr[11:2]];
          end
          streak = if_req ? ((streak < SM) ? streak + 1 : SM) : 0;
        end
        pend_d = !take_if; pend_oor = oor; inflight = 1;
      end
      chk1("rnd if_gnt", if_gnt, e_ifg);
      chk1("rnd d_gnt", d_gnt, e_dg);
      chk1("rnd mem_read", mem_read, e_rd);
      chk1("rnd mem_write", mem_write, e_wr);
      chk1("rnd if_rvalid", if_rvalid, e_ifv);
      chk1("rnd d_rvalid", d_rvalid, e_dv);
      chk1("rnd d_err", d_err, e_err);
      if (e_rd || e_wr) chk32("rnd mem_addr", mem_addr, e_maddr);
      if (e_wr) chk32("rnd mem_wdata", mem_wdata, d_wdata);
      if (e_ifv) chk32("rnd if_rdata", if_rdata, e_rdata);
      if (e_dv) chk32("rnd d_rdata", d_rdata, e_rdata);
      saw_if_gnt = if_gnt; saw_d_gnt = d_gnt;
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 4096, byte size of the shared RAM.
REQ-002 SHALL have parameter STARVE_MAX, default 4, the number of consecutive data grants allowed while fetch waits.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-005 SHALL have ports if_req (in, 1), if_addr (in, 32), if_gnt (out, 1), if_rvalid (out, 1) and if_rdata (out, 32) for instruction fetch.
REQ-006 SHALL have ports d_req (in, 1), d_we (in, 1), d_addr (in, 32), d_wdata (in, 32), d_gnt (out, 1), d_rvalid (out, 1), d_rdata (out, 32) and d_err (out, 1) for load/store.
REQ-007 SHALL have RAM-side ports mem_addr (out, 32), mem_read (out, 1), mem_write (out, 1), mem_wdata (out, 32) and mem_rdata (in, 32), with mem_rdata valid one cycle after mem_read.

Function
REQ-008 SHALL use the FSM states IDLE, BUSY_IF and BUSY_D.
REQ-009 In IDLE with any request, SHALL assert exactly one gnt combinationally and drive the mem_* command in that same cycle, then go to BUSY_IF or BUSY_D.
REQ-010 SHALL give data priority over fetch when both request, subject to REQ-021.
REQ-011 In BUSY_x, SHALL register mem_rdata into x_rdata, pulse x_rvalid for one cycle, and return to IDLE; no grant is issued in a BUSY state.
REQ-012 Each access SHALL take 2 cycles, giving a throughput of one access per 2 cycles.
REQ-013 A data write SHALL assert mem_write in the grant cycle and pulse d_rvalid the next cycle with d_rdata = 0.
REQ-014 SHALL treat any address with addr + 3 >= MEM_BYTES (computed in 33-bit arithmetic, no wrap) as out of range.
REQ-015 An out-of-range access SHALL still be granted, SHALL NOT assert mem_read or mem_write, and SHALL complete with rvalid and rdata = 0; for the data port it SHALL also set d_err = 1 for that rvalid cycle only.
REQ-016 Requesters SHALL hold req, addr, we and wdata stable until gnt; the arbiter samples them only in the grant cycle.
REQ-017 Dropping req before gnt SHALL be legal and SHALL have no side effect.
REQ-018 mem_read and mem_write SHALL never both be high, and SHALL be low outside grant cycles.

Reset
REQ-019 While rst is high, SHALL enter IDLE and hold all outputs at 0: gnts, rvalids, rdata, d_err, mem_read, mem_write, mem_addr and mem_wdata.
REQ-020 Reset during BUSY_x SHALL abort the pending rvalid, so no rvalid is emitted after reset deasserts; the starvation counter SHALL clear to 0.

Configuration
REQ-021 With MEM_ARB_FAIR_EN defined:
- a 3-bit-or-wider counter SHALL count consecutive data grants made while if_req was high;
- when the count reaches STARVE_MAX and both ports request, fetch SHALL win;
- the counter SHALL clear on any fetch grant, or when if_req is low at a data grant.
REQ-022 Without MEM_ARB_FAIR_EN, no counter SHALL exist and strict data priority SHALL apply.

Structure
REQ-023 SHALL place the state enum (IDLE/BUSY_IF/BUSY_D) and the default MEM_BYTES and STARVE_MAX constants in the shared package mem_pkg.
REQ-024 SHALL be a single module with no sub-modules; the range check is inline combinational logic.

Verification
REQ-025 Fetch-only read: if_req with if_addr=0x10 and RAM word 0xDEADBEEF -> if_gnt in cycle 0, if_rvalid with if_rdata=0xDEADBEEF in cycle 1.
REQ-026 Simultaneous requests: if_req and d_req together -> d_gnt first; if_gnt 2 cycles later if if_req is still held.
REQ-027 Write then read: store d_wdata=0x12345678 at 0x100, then load 0x100 -> d_rdata=0x12345678, d_err=0.
REQ-028 Out of range: d_addr=0xFFD with MEM_BYTES=4096 -> no mem_read, d_rvalid with d_rdata=0 and d_err=1.
REQ-029 Fairness: with MEM_ARB_FAIR_EN and both ports requesting continuously -> if_gnt on every 5th grant (after 4 d_gnt); without the macro -> if_gnt never.
REQ-030 Reset mid-access: rst in a BUSY_D cycle -> no d_rvalid afterwards, all outputs 0, and the next request is granted normally.
